// File: rtl/mnist_input_binarize_pack_if.sv
// Streaming pixel-in / packed-frame-out bus for the MNIST input binariser.
// slave = the binariser itself, master = whatever drives pixels and consumes frames.
interface mnist_input_binarize_pack_if #(
  parameter int NUM_PIX = 784,
  parameter int PIX_W   = 8
);
  logic [PIX_W-1:0]   s_pixel;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  logic [NUM_PIX-1:0] m_data;
  logic               m_valid;
  logic               m_ready;
  logic               frame_err;

  modport slave (
    input  s_pixel, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, frame_err
  );

  modport master (
    output s_pixel, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, frame_err
  );
endinterface

// File: rtl/mnist_input_binarize_pack.sv
// Binarises a pixel stream against THRESH and packs one frame into an NUM_PIX-bit
// vector for the layer-0 fan-out; malformed frames raise a one-cycle frame_err.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   FILL    | accepting pixels, writing m_data[idx]
//   DRAIN   | frame overran without s_last; discarding beats up to s_last
//   PRESENT | complete frame on m_data, waiting for m_ready
module mnist_input_binarize_pack #(
  parameter int NUM_PIX = 784,
  parameter int PIX_W   = 8,
  parameter int THRESH  = 128
) (
  input  logic clk,
  input  logic rst,
  mnist_input_binarize_pack_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_PIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIX - 1);
  localparam logic [PIX_W-1:0] THRESH_V = PIX_W'(THRESH);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DRAIN   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_PIX-1:0] data_q, data_d;
  logic               err_q, err_d;
  logic               rdy_en_q;

  logic s_ready;
  logic beat;
  logic pix_bit;

  // rdy_en_q holds s_ready low through reset and releases it on the first edge after.
  assign s_ready = rdy_en_q & (state_q != PRESENT);
  assign beat    = bus.s_valid & s_ready;
  assign pix_bit = (bus.s_pixel >= THRESH_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      idx_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (beat) begin
          data_d[idx_q] = pix_bit;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (bus.s_last) begin
              state_d = PRESENT;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (bus.s_last) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (beat && bus.s_last) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      PRESENT: begin
        if (bus.m_ready) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.s_ready   = s_ready;
  assign bus.m_valid   = (state_q == PRESENT);
  assign bus.m_data    = data_q;
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_mnist_input_binarize_pack.sv
// Directed bench for mnist_input_binarize_pack: reset, threshold edges,
// back-pressure, framing errors and gapped multi-frame traffic.
module tb_mnist_input_binarize_pack;
  localparam int NUM_PIX = 784;
  localparam int PIX_W   = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   hs_cnt;
  int   err_cnt;

  logic [PIX_W-1:0]   pix [NUM_PIX];
  logic [NUM_PIX-1:0] exp_data;

  mnist_input_binarize_pack_if #(.NUM_PIX(NUM_PIX), .PIX_W(PIX_W)) bus ();

  mnist_input_binarize_pack #(.NUM_PIX(NUM_PIX), .PIX_W(PIX_W), .THRESH(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.m_valid && bus.m_ready) hs_cnt <= hs_cnt + 1;
    if (bus.frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [NUM_PIX-1:0] obs, input logic [NUM_PIX-1:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, obs, expv);
    end
  endtask

  task automatic build_exp();
    for (int k = 0; k < NUM_PIX; k++) exp_data[k] = (pix[k] >= 8'd128);
  endtask

  task automatic drive_beat(input logic [PIX_W-1:0] p, input logic l, input int gap_pct);
    int n;
    if (gap_pct > 0) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.s_pixel = p;
    bus.s_last  = l;
    bus.s_valid = 1'b1;
    n = 0;
    while (!bus.s_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) chk("beat_timeout", '0, 1);
    @(posedge clk); #1;
  endtask

  // last_at < 0 sends NUM_PIX beats without any s_last.
  task automatic send_frame(input int last_at, input int gap_pct);
    int nb;
    nb = (last_at < 0) ? NUM_PIX : last_at + 1;
    for (int k = 0; k < nb; k++) drive_beat(pix[k], (k == last_at), gap_pct);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic handshake();
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    chk("hs_mvalid_low", NUM_PIX'(bus.m_valid), NUM_PIX'(0));
    chk("hs_sready_high", NUM_PIX'(bus.s_ready), NUM_PIX'(1));
  endtask

  task automatic deliver_frame(input string tag, input int gap_pct);
    build_exp();
    send_frame(NUM_PIX - 1, gap_pct);
    chk({tag, "_mvalid"}, NUM_PIX'(bus.m_valid), NUM_PIX'(1));
    chk({tag, "_mdata"}, bus.m_data, exp_data);
    handshake();
  endtask

  task automatic rand_pix();
    for (int k = 0; k < NUM_PIX; k++) pix[k] = PIX_W'($urandom_range(0, 255));
  endtask

  initial begin
    n_vec = 0; n_err = 0; hs_cnt = 0; err_cnt = 0;
    rst = 1'b1;
    bus.s_pixel = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sready", NUM_PIX'(bus.s_ready), NUM_PIX'(0));
    chk("rst_mdata", bus.m_data, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_sready", NUM_PIX'(bus.s_ready), NUM_PIX'(1));

    // 1: reset while 300 pixels are in flight
    for (int k = 0; k < NUM_PIX; k++) pix[k] = 8'd255;
    for (int k = 0; k < 300; k++) drive_beat(pix[k], 1'b0, 0);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("midrst_sready", NUM_PIX'(bus.s_ready), NUM_PIX'(0));
    chk("midrst_mvalid", NUM_PIX'(bus.m_valid), NUM_PIX'(0));
    chk("midrst_ferr", NUM_PIX'(bus.frame_err), NUM_PIX'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rel_sready_low", NUM_PIX'(bus.s_ready), NUM_PIX'(0));
    @(posedge clk); #1;
    rand_pix();
    deliver_frame("t1", 0);

    // 2: threshold edges
    for (int k = 0; k < NUM_PIX; k++) pix[k] = 8'd200;
    pix[0] = 8'd127; pix[1] = 8'd128; pix[2] = 8'd255; pix[3] = 8'd0;
    send_frame(NUM_PIX - 1, 0);
    chk("t2_mvalid", NUM_PIX'(bus.m_valid), NUM_PIX'(1));
    chk("t2_low4", NUM_PIX'(bus.m_data[3:0]), NUM_PIX'(4'b0110));
    chk("t2_upper", NUM_PIX'(bus.m_data[NUM_PIX-1:4]), NUM_PIX'({(NUM_PIX-4){1'b1}}));
    handshake();

    // 3: back-pressure, upstream keeps offering a beat that must not be taken
    rand_pix();
    build_exp();
    send_frame(NUM_PIX - 1, 0);
    bus.s_valid = 1'b1; bus.s_pixel = 8'd0; bus.s_last = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("t3_mvalid", NUM_PIX'(bus.m_valid), NUM_PIX'(1));
      chk("t3_sready", NUM_PIX'(bus.s_ready), NUM_PIX'(0));
      chk("t3_mdata", bus.m_data, exp_data);
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    handshake();

    // 4: early s_last at pixel 10
    rand_pix();
    send_frame(10, 0);
    chk("t4_ferr_pulse", NUM_PIX'(bus.frame_err), NUM_PIX'(1));
    chk("t4_mvalid", NUM_PIX'(bus.m_valid), NUM_PIX'(0));
    @(posedge clk); #1;
    chk("t4_ferr_clear", NUM_PIX'(bus.frame_err), NUM_PIX'(0));
    rand_pix();
    pix[0] = 8'd255; pix[1] = 8'd0;
    deliver_frame("t4", 0);
    chk("t4_bit0", NUM_PIX'(bus.m_data[1:0]), NUM_PIX'(2'b01));

    // 5: missing s_last, then 5 junk beats ending on s_last
    rand_pix();
    send_frame(-1, 0);
    chk("t5_ferr_pulse", NUM_PIX'(bus.frame_err), NUM_PIX'(1));
    chk("t5_drain_sready", NUM_PIX'(bus.s_ready), NUM_PIX'(1));
    for (int j = 0; j < 5; j++) begin
      drive_beat(8'd255, (j == 4), 0);
      chk("t5_junk_ferr", NUM_PIX'(bus.frame_err), NUM_PIX'(0));
      chk("t5_junk_mvalid", NUM_PIX'(bus.m_valid), NUM_PIX'(0));
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    rand_pix();
    deliver_frame("t5", 0);

    // 6: 50 frames with ~30% idle cycles
    @(posedge clk); #1;
    hs_cnt = 0; err_cnt = 0;
    for (int f = 0; f < 50; f++) begin
      rand_pix();
      deliver_frame("t6", 30);
    end
    @(posedge clk); #1;
    chk("t6_frames", NUM_PIX'(hs_cnt), NUM_PIX'(50));
    chk("t6_no_ferr", NUM_PIX'(err_cnt), NUM_PIX'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
